// File: rtl/alu_sched_pkg.sv
// Shared constants for the alu_sched command scheduler: FSM encoding,
// ALU opcodes and default datapath widths.
package alu_sched_pkg;

  localparam int INST_W = 4;
  localparam int DATA_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;

endpackage

// File: rtl/alu_sched_if.sv
// Bundle of requester, ALU and response signals seen by alu_sched.
// The slave modport is the scheduler's view; master is the environment's.
interface alu_sched_if
  import alu_sched_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int INST_W = alu_sched_pkg::INST_W,
  parameter int DATA_W = alu_sched_pkg::DATA_W
);
  localparam int IDX_W = $clog2(N_REQ);

  logic [N_REQ-1:0]        i_req_valid;
  logic [N_REQ-1:0]        o_req_ready;
  logic [N_REQ*INST_W-1:0] i_req_inst;
  logic [N_REQ*DATA_W-1:0] i_req_data_a;
  logic [N_REQ*DATA_W-1:0] i_req_data_b;
  logic                    o_alu_valid;
  logic [INST_W-1:0]       o_alu_inst;
  logic [DATA_W-1:0]       o_alu_data_a;
  logic [DATA_W-1:0]       o_alu_data_b;
  logic                    i_alu_busy;
  logic                    i_alu_out_valid;
  logic [DATA_W-1:0]       i_alu_data;
  logic                    o_rsp_valid;
  logic [IDX_W-1:0]        o_rsp_id;
  logic [DATA_W-1:0]       o_rsp_data;
  logic                    o_rsp_err;
  logic                    i_rsp_ready;

  modport slave (
    input  i_req_valid, i_req_inst, i_req_data_a, i_req_data_b,
    input  i_alu_busy, i_alu_out_valid, i_alu_data, i_rsp_ready,
    output o_req_ready, o_alu_valid, o_alu_inst, o_alu_data_a, o_alu_data_b,
    output o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err
  );

  modport master (
    output i_req_valid, i_req_inst, i_req_data_a, i_req_data_b,
    output i_alu_busy, i_alu_out_valid, i_alu_data, i_rsp_ready,
    input  o_req_ready, o_alu_valid, o_alu_inst, o_alu_data_a, o_alu_data_b,
    input  o_rsp_valid, o_rsp_id, o_rsp_data, o_rsp_err
  );

endinterface

// File: rtl/alu_sched_rr_arb.sv
// Combinational round-robin pick: first set request at or after i_ptr,
// wrapping, returned as a one-hot grant and an index.
module alu_sched_rr_arb
  import alu_sched_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!o_any && i_req[(int'(i_ptr) + i) % N_REQ]) begin
        o_any = 1'b1;
        o_idx = IDX_W'((int'(i_ptr) + i) % N_REQ);
        o_grant[(int'(i_ptr) + i) % N_REQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one Q6.10 ALU between N_REQ requesters.
// Define ALU_SCHED_TIMEOUT_EN to build the WAIT watchdog (abort after TIMEOUT cycles).
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int INST_W  = alu_sched_pkg::INST_W,
  parameter int DATA_W  = alu_sched_pkg::DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst,
  alu_sched_if.slave io_bus
);

  localparam int IDX_W = $clog2(N_REQ);

  if (N_REQ < 2 || TIMEOUT < 1) begin : g_bad_param
    $error("alu_sched: N_REQ must be >= 2 and TIMEOUT >= 1");
  end

  logic [1:0]        r_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic [IDX_W-1:0]  r_gnt_id;
  logic [INST_W-1:0] r_inst;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [IDX_W-1:0]  r_rsp_id;
  logic [DATA_W-1:0] r_rsp_data;

  logic [N_REQ-1:0]  w_grant;
  logic [IDX_W-1:0]  w_gnt_idx;
  logic              w_any;
  logic              w_accept;

  alu_sched_rr_arb #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
    .i_req   (io_bus.i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gnt_idx),
    .o_any   (w_any)
  );

  // Accept is a same-cycle pulse so a requester sees ready while still presenting.
  assign w_accept = (r_state == ST_IDLE) && w_any && !io_bus.i_alu_busy && !i_rst;

  assign io_bus.o_req_ready  = w_accept ? w_grant : '0;
  assign io_bus.o_alu_valid  = (r_state == ST_ISSUE);
  assign io_bus.o_alu_inst   = r_inst;
  assign io_bus.o_alu_data_a = r_a;
  assign io_bus.o_alu_data_b = r_b;
  assign io_bus.o_rsp_valid  = (r_state == ST_RESP);
  assign io_bus.o_rsp_id     = r_rsp_id;
  assign io_bus.o_rsp_data   = r_rsp_data;

`ifdef ALU_SCHED_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_rsp_err;
  assign io_bus.o_rsp_err = r_rsp_err;
`else
  assign io_bus.o_rsp_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_gnt_id   <= '0;
      r_inst     <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_rsp_id   <= '0;
      r_rsp_data <= '0;
`ifdef ALU_SCHED_TIMEOUT_EN
      r_wait_cnt <= '0;
      r_rsp_err  <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_gnt_id <= w_gnt_idx;
            r_inst   <= io_bus.i_req_inst[w_gnt_idx*INST_W +: INST_W];
            r_a      <= io_bus.i_req_data_a[w_gnt_idx*DATA_W +: DATA_W];
            r_b      <= io_bus.i_req_data_b[w_gnt_idx*DATA_W +: DATA_W];
            r_state  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
`ifdef ALU_SCHED_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        // Instruction and operands stay on the ALU bus: its output mux follows i_inst.
        ST_WAIT: begin
          if (io_bus.i_alu_out_valid) begin
            r_rsp_data <= io_bus.i_alu_data;
            r_rsp_id   <= r_gnt_id;
`ifdef ALU_SCHED_TIMEOUT_EN
            r_rsp_err  <= 1'b0;
`endif
            r_state    <= ST_RESP;
          end
`ifdef ALU_SCHED_TIMEOUT_EN
          else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_rsp_data <= '0;
            r_rsp_id   <= r_gnt_id;
            r_rsp_err  <= 1'b1;
            r_state    <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (io_bus.i_rsp_ready) begin
            r_rr_ptr <= (r_gnt_id == IDX_W'(N_REQ - 1)) ? '0 : r_gnt_id + 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin command scheduler placed in front of the Q6.10 fixed-point `alu`. It shares the single ALU between `N_REQ` requesters. Each cycle it accepts at most one command and issues it to the ALU with a one-cycle valid pulse. It holds the instruction stable until the ALU result returns, then hands the result back to the winning requester, tagged with that requester's index.

## Interface
- `N_REQ`, 2: number of requesters (≥2).
- `INST_W`, 4: instruction width.
- `DATA_W`, 16: data width (Q6.10).
- `TIMEOUT`, 15: maximum WAIT cycles before abort. Used only with the watchdog compiled in.
- `i_clk`  in  1: single clock, rising edge.
- `i_rst`  in  1: reset, synchronous and active-high.
- `i_req_valid`  in  N_REQ: per-requester command valid.
- `o_req_ready`  out  N_REQ: one-hot accept pulse.
- `i_req_inst`  in  N_REQ*INST_W: packed instructions; requester k occupies slice k.
- `i_req_data_a`, `i_req_data_b`  in  N_REQ*DATA_W: packed operands.
- `o_alu_valid`  out  1: drives ALU `i_in_valid`.
- `o_alu_inst`  out  INST_W: drives ALU `i_inst`.
- `o_alu_data_a`, `o_alu_data_b`  out  DATA_W: drive ALU operands.
- `i_alu_busy`  in  1: ALU `o_busy`.
- `i_alu_out_valid`  in  1: ALU `o_out_valid`.
- `i_alu_data`  in  DATA_W: ALU `o_data`.
- `o_rsp_valid`  out  1: response valid.
- `o_rsp_id`  out  $clog2(N_REQ): index of the requester that owns the response.
- `o_rsp_data`  out  DATA_W: result.
- `o_rsp_err`  out  1: watchdog abort flag. Constant 0 without the macro.
- `i_rsp_ready`  in  1: response consumer ready.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Arbitration runs when any `i_req_valid` bit is set and `i_alu_busy` is 0.
  - Round-robin search starts at pointer `rr_ptr`; the first valid index at or after `rr_ptr`, wrapping, wins.
  - For the winner g: `o_req_ready[g]`=1 for this cycle only, and inst/a/b[g] and g are latched into hold registers. Next state is ISSUE.
  - A requester must keep its command stable while valid until it is accepted.
- **ISSUE**
  - `o_alu_valid`=1 for exactly one cycle, with the held inst/a/b. Next state is WAIT.
- **WAIT**
  - `o_alu_valid`=0; `o_alu_inst`, `o_alu_data_a`, `o_alu_data_b` stay held. This is required because the ALU output mux depends on `i_inst`.
  - When `i_alu_out_valid`=1: capture `i_alu_data` into `o_rsp_data`, set `o_rsp_id`=g and `o_rsp_err`=0. Next state is RESP.
- **RESP**
  - `o_rsp_valid`=1; id, data and err are held stable until `i_rsp_ready`=1.
  - On that handshake: `rr_ptr` ← (g+1) mod N_REQ. Next state is IDLE.
- No arithmetic is done in this block. The ALU result passes through unmodified, including its saturation.
- `i_alu_out_valid` is ignored outside WAIT.
- **Reset** (any state): state=IDLE, `rr_ptr`=0, hold registers=0, and every output is 0 (`o_req_ready`, `o_alu_*`, `o_rsp_*`). An in-flight command is dropped with no response.

## Timing
- Accept (cycle 0, IDLE) → `o_alu_valid` (cycle 1) → ALU `o_out_valid` (cycle 2) → `o_rsp_valid` (cycle 3).
- Minimum issue interval is 4 cycles, with `i_rsp_ready` held at 1.
- Response backpressure stalls the block in RESP. No new accept happens while `o_rsp_valid`=1.
- When all requesters assert valid continuously, grants rotate 0,1,…,N_REQ-1,0.
- A lone valid requester wins regardless of `rr_ptr`.
- While `i_alu_busy`=1 in IDLE, no grant is made and `o_req_ready`=0.

## Configuration
- **`ALU_SCHED_TIMEOUT_EN` defined:**
  - A 4-bit-or-wider wait counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches `TIMEOUT` without `i_alu_out_valid`: `o_rsp_data`=0, `o_rsp_err`=1, `o_rsp_id`=g. Next state is RESP.
  - This covers opcodes that the ALU never acknowledges.
- **Undefined:** no counter is built, WAIT lasts until `i_alu_out_valid`, and `o_rsp_err` is tied to 0.

## Structure
- Shared package `alu_sched_pkg` holds:
  - the state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - opcode constants OP_ADD=4'b0000 and OP_SUB=4'b0001;
  - default widths INST_W=4 and DATA_W=16.
- One sub-module, `alu_sched_rr_arb`: combinational round-robin pick (req vector, pointer → one-hot grant plus index). The FSM and hold registers stay in `alu_sched`.

## Test plan
- **ADD:** req0 ADD a=0x0400, b=0x0200 (1.0+0.5). Expect `o_req_ready`=01 at cycle 0, `o_alu_valid` at cycle 1, `o_rsp_valid` at cycle 3 with id=0, data=0x0600, err=0.
- **Saturation pass-through:** req1 ADD a=0x7FFF, b=0x0001. Expect a response with id=1, data=0x7FFF.
- **Contention:** req0 SUB 0x0800−0x0400 and req1 ADD 0x0100+0x0100 held valid together from reset. Expect responses id=0/0x0400, then id=1/0x0200, then req0 wins the next grant.
- **Backpressure:** hold `i_rsp_ready`=0 for 5 cycles in RESP. Expect `o_rsp_valid`/id/data stable and `o_req_ready`=0 throughout; exit on the cycle `i_rsp_ready`=1.
- **Busy and timeout:**
  - Hold `i_alu_busy`=1 for 3 cycles with req0 valid: no grant occurs until busy drops.
  - With `ALU_SCHED_TIMEOUT_EN`, inst 4'b1111 with no ALU valid: after 15 WAIT cycles, expect a response with data=0, err=1.
- **Reset mid-operation:** assert `i_rst` in WAIT. Next cycle all outputs are 0 and state is IDLE; no response is emitted for the dropped command, and a fresh req1 command is granted first.
